// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator request scheduler.
package elevator_pkg;

   localparam int unsigned NUM_FLOORS_DEFAULT = 8;
   localparam int unsigned DOOR_DWELL_DEFAULT = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      MOVE   = 2'd2,
      DOOR   = 2'd3
   } sched_state_t;

endpackage

// File: rtl/elevator_floor_picker.sv
// Combinational SCAN pick: nearest pending floor ahead, else reverse; a call at the current floor wins.
module elevator_floor_picker
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEFAULT
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [NUM_FLOORS-1:0] cur_floor,
   input  logic                  dir,
   output logic [NUM_FLOORS-1:0] pick,
   output logic                  pick_valid,
   output logic                  new_dir,
   output logic                  at_cur
);

   logic [NUM_FLOORS-1:0] above;
   logic [NUM_FLOORS-1:0] below;
   logic [NUM_FLOORS-1:0] lowest_above;
   logic [NUM_FLOORS-1:0] highest_below;
   logic                  seen_lo;
   logic                  seen_hi;
   logic                  found;

   // Split pending into floors strictly above / below the car, then isolate the nearest of each.
   always_comb begin
      above         = '0;
      below         = '0;
      highest_below = '0;
      seen_lo       = 1'b0;
      seen_hi       = 1'b0;
      found         = 1'b0;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         above[i] = pending[i] & seen_lo;
         seen_lo  = seen_lo | cur_floor[i];
      end
      for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
         below[i] = pending[i] & seen_hi;
         seen_hi  = seen_hi | cur_floor[i];
         if (below[i] && !found) begin
            highest_below[i] = 1'b1;
            found            = 1'b1;
         end
      end
      lowest_above = above & (~above + NUM_FLOORS'(1));
   end

   always_comb begin
      pick       = '0;
      new_dir    = dir;
      at_cur     = |(pending & cur_floor);
      pick_valid = at_cur | (|above) | (|below);
      if (at_cur) begin
         pick = cur_floor;
      end else if (dir == DIR_UP) begin
         if (|above) begin
            pick = lowest_above;
         end else if (|below) begin
            pick    = highest_below;
            new_dir = DIR_DOWN;
         end
      end else begin
         if (|below) begin
            pick = highest_below;
         end else if (|above) begin
            pick    = lowest_above;
            new_dir = DIR_UP;
         end
      end
   end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls, drives the controller toward the next SCAN target and times the door dwell.
module elevator_request_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEFAULT,
   parameter int unsigned DOOR_DWELL = DOOR_DWELL_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [NUM_FLOORS-1:0] cur_floor,
   input  logic                  complete,
   input  logic                  hold,
   output logic [NUM_FLOORS-1:0] target_floor,
   output logic                  target_valid,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  door_open,
   output logic                  sched_dir,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(DOOR_DWELL + 1);

   sched_state_t          state, state_nxt;
   logic [CNT_W-1:0]      dwell, dwell_nxt;
   logic [NUM_FLOORS-1:0] pending_nxt, target_nxt, pick_src, pick, call_lat;
   logic                  tv_nxt, door_nxt, dir_nxt, busy_nxt;
   logic                  pick_valid, new_dir, at_cur, cur_onehot, reopen, pickup_ok;

   // While moving, the floor being passed is not a pick-up candidate.
   assign pick_src   = (state == MOVE) ? (pending & ~cur_floor) : pending;
   assign cur_onehot = (cur_floor != '0) && ((cur_floor & (cur_floor - NUM_FLOORS'(1))) == '0);
   assign reopen     = (state == DOOR) && (|(call_req & cur_floor));
   assign call_lat   = (state == DOOR) ? (call_req & ~cur_floor) : call_req;
   assign pickup_ok  = pick_valid && cur_onehot &&
                       ((sched_dir == DIR_UP) ? ((pick > cur_floor) && (pick < target_floor))
                                              : ((pick < cur_floor) && (pick > target_floor)));

   elevator_floor_picker #(.NUM_FLOORS(NUM_FLOORS)) u_picker (
      .pending    (pick_src),
      .cur_floor  (cur_floor),
      .dir        (sched_dir),
      .pick       (pick),
      .pick_valid (pick_valid),
      .new_dir    (new_dir),
      .at_cur     (at_cur)
   );

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending | call_lat;
      target_nxt  = target_floor;
      tv_nxt      = target_valid;
      door_nxt    = door_open;
      dir_nxt     = sched_dir;
      dwell_nxt   = dwell;
      case (state)
         IDLE: begin
            if (pending_nxt != '0) state_nxt = SELECT;
         end
         SELECT: begin
            tv_nxt = 1'b0;
            if (!cur_onehot) begin
               state_nxt = SELECT;
            end else if (!pick_valid) begin
               state_nxt = IDLE;
            end else if (at_cur) begin
               state_nxt   = DOOR;
               door_nxt    = 1'b1;
               dwell_nxt   = CNT_W'(DOOR_DWELL);
               pending_nxt = pending_nxt & ~cur_floor;
            end else begin
               state_nxt  = MOVE;
               target_nxt = pick;
               dir_nxt    = new_dir;
               tv_nxt     = 1'b1;
            end
         end
         MOVE: begin
            tv_nxt = 1'b1;
            if (complete && (cur_floor == target_floor)) begin
               state_nxt   = DOOR;
               tv_nxt      = 1'b0;
               door_nxt    = 1'b1;
               dwell_nxt   = CNT_W'(DOOR_DWELL);
               pending_nxt = pending_nxt & ~target_floor;
            end else if (pickup_ok) begin
               target_nxt = pick;
            end
         end
         DOOR: begin
            door_nxt = 1'b1;
            if (reopen) begin
               dwell_nxt = CNT_W'(DOOR_DWELL);
            end else if (!hold) begin
               if (dwell <= CNT_W'(1)) begin
                  dwell_nxt = '0;
                  door_nxt  = 1'b0;
                  state_nxt = (pending_nxt != '0) ? SELECT : IDLE;
               end else begin
                  dwell_nxt = dwell - CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pending      <= '0;
         target_floor <= '0;
         target_valid <= 1'b0;
         door_open    <= 1'b0;
         sched_dir    <= DIR_UP;
         busy         <= 1'b0;
         dwell        <= '0;
      end else begin
         state        <= state_nxt;
         pending      <= pending_nxt;
         target_floor <= target_nxt;
         target_valid <= tv_nxt;
         door_open    <= door_nxt;
         sched_dir    <= dir_nxt;
         busy         <= busy_nxt;
         dwell        <= dwell_nxt;
      end
   end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Self-checking bench: single-call vector table plus SCAN, pick-up, hold/re-open and reset sequences.
module tb_elevator_request_scheduler;

   localparam int unsigned NF = 8;
   localparam int unsigned DW = 4;

   typedef struct {
      logic [NF-1:0] cur;
      logic [NF-1:0] call;
      logic [NF-1:0] exp_target;
      logic          exp_dir;
      logic          door_only;
   } vec_t;

   typedef struct {
      logic [NF-1:0] target;
      logic          dir;
      logic          door_only;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [NF-1:0] call_req, cur_floor, target_floor, pending;
   logic          complete, hold, target_valid, door_open, sched_dir, busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[7];
   exp_t sb[$];

   always #5 clk = ~clk;

   elevator_request_scheduler #(.NUM_FLOORS(NF), .DOOR_DWELL(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .call_req     (call_req),
      .cur_floor    (cur_floor),
      .complete     (complete),
      .hold         (hold),
      .target_floor (target_floor),
      .target_valid (target_valid),
      .pending      (pending),
      .door_open    (door_open),
      .sched_dir    (sched_dir),
      .busy         (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tv(input string name);
      int n = 0;
      while (!target_valid && n < 20) begin
         step();
         n++;
      end
      check(name, target_valid, 1);
   endtask

   task automatic arrive(input logic [NF-1:0] flr);
      cur_floor = flr;
      complete  = 1'b1;
      step();
      complete  = 1'b0;
      check("arrive_door", door_open, 1);
      check("arrive_tv_clr", target_valid, 0);
   endtask

   // Counts sampled cycles with door_open high, optionally holding or re-calling the current floor.
   task automatic measure_door(input int hold_from, input int hold_n, input int reopen_at,
                               output int cnt);
      cnt = 0;
      while (door_open && cnt < 100) begin
         cnt++;
         hold     = (cnt >= hold_from) && (cnt < hold_from + hold_n);
         call_req = (cnt == reopen_at) ? cur_floor : '0;
         step();
      end
      hold     = 1'b0;
      call_req = '0;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   lat;
      int   cnt;
      cur_floor = v.cur;
      call_req  = v.call;
      sb.push_back(exp_t'{v.exp_target, v.exp_dir, v.door_only});
      step();
      call_req = '0;
      check("pending_latch", pending, v.call);
      lat = 1;
      while (!target_valid && !door_open && lat < 20) begin
         step();
         lat++;
      end
      check("start_latency", lat, 2);
      e = sb.pop_front();
      check("dir", sched_dir, e.dir);
      if (e.door_only) begin
         check("no_tv_at_cur", target_valid, 0);
         check("door_at_cur", door_open, 1);
      end else begin
         check("target", target_floor, e.target);
         step();
         step();
         check("tv_held", target_valid, 1);
         arrive(e.target);
      end
      measure_door(0, 0, 0, cnt);
      check("dwell", cnt, DW);
      check("idle_busy", busy, 0);
      check("idle_pending", pending, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      vecs[0] = '{8'h01, 8'h10, 8'h10, 1'b1, 1'b0};
      vecs[1] = '{8'h10, 8'h02, 8'h02, 1'b0, 1'b0};
      vecs[2] = '{8'h02, 8'h01, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'h01, 8'h80, 8'h80, 1'b1, 1'b0};
      vecs[4] = '{8'h04, 8'h04, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{8'h80, 8'h08, 8'h08, 1'b0, 1'b0};
      vecs[6] = '{8'h08, 8'h08, 8'h00, 1'b0, 1'b1};

      reset     = 1'b0;
      call_req  = '0;
      cur_floor = 8'h01;
      complete  = 1'b0;
      hold      = 1'b0;
      #17;
      check("rst_tv", target_valid, 0);
      check("rst_door", door_open, 0);
      check("rst_pending", pending, 0);
      check("rst_target", target_floor, 0);
      check("rst_dir", sched_dir, 1);
      check("rst_busy", busy, 0);
      reset = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // SCAN order: both ends called together while heading up from the middle.
      reset = 1'b0;
      #2;
      reset = 1'b1;
      step();
      cur_floor = 8'h08;
      call_req  = 8'h41;
      step();
      call_req = '0;
      wait_tv("scan_tv1");
      check("scan_first", target_floor, 8'h40);
      check("scan_dir1", sched_dir, 1);
      arrive(8'h40);
      check("scan_pend_left", pending, 8'h01);
      measure_door(0, 0, 0, cnt);
      check("scan_dwell1", cnt, DW);
      wait_tv("scan_tv2");
      check("scan_second", target_floor, 8'h01);
      check("scan_dir2", sched_dir, 0);
      arrive(8'h01);
      measure_door(0, 0, 0, cnt);
      check("scan_pend_empty", pending, 0);

      // Pick-up on the way up, plus a complete for the wrong floor.
      cur_floor = 8'h02;
      call_req  = 8'h80;
      step();
      call_req = '0;
      wait_tv("pu_tv");
      check("pu_target80", target_floor, 8'h80);
      check("pu_dir", sched_dir, 1);
      cur_floor = 8'h04;
      step();
      call_req = 8'h10;
      step();
      call_req = '0;
      step();
      check("pu_target10", target_floor, 8'h10);
      check("pu_tv_kept", target_valid, 1);
      complete = 1'b1;
      step();
      complete = 1'b0;
      check("wrong_cmpl_door", door_open, 0);
      check("wrong_cmpl_tv", target_valid, 1);
      arrive(8'h10);
      check("pu_pend80", pending, 8'h80);
      measure_door(0, 0, 0, cnt);
      wait_tv("pu_tv2");
      check("pu_then80", target_floor, 8'h80);
      arrive(8'h80);
      measure_door(0, 0, 0, cnt);
      check("pu_idle", busy, 0);

      // Hold extends the dwell by one cycle per hold cycle.
      call_req = 8'h80;
      step();
      call_req = '0;
      step();
      check("hold_door_on", door_open, 1);
      measure_door(2, 3, 0, cnt);
      check("hold_dwell", cnt, DW + 3);

      // Re-open: current-floor call during DOOR reloads the dwell and is not latched.
      call_req = 8'h80;
      step();
      call_req = '0;
      step();
      measure_door(0, 0, 2, cnt);
      check("reopen_dwell", cnt, DW + 2);
      check("reopen_pending", pending, 0);
      check("reopen_idle", busy, 0);

      // Async reset mid-MOVE after the direction has turned down.
      call_req = 8'h01;
      step();
      call_req = '0;
      wait_tv("ar_tv");
      check("ar_dir_down", sched_dir, 0);
      #3;
      reset = 1'b0;
      #1;
      check("ar_tv", target_valid, 0);
      check("ar_door", door_open, 0);
      check("ar_pending", pending, 0);
      #2;
      reset = 1'b1;
      step();
      check("ar_dir_up", sched_dir, 1);
      check("ar_busy", busy, 0);

      // Async reset mid-DOOR.
      cur_floor = 8'h40;
      call_req  = 8'h40;
      step();
      call_req = '0;
      step();
      check("ad_door_on", door_open, 1);
      #3;
      reset = 1'b0;
      #1;
      check("ad_door", door_open, 0);
      check("ad_busy", busy, 0);
      #2;
      reset = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Collects floor calls from hall and cab buttons and holds them as a pending set. Chooses the next target floor with a SCAN policy: keep travelling in the current direction while calls remain ahead, otherwise reverse. Presents the target as a one-hot floor to the elevator controller, waits for arrival, then times the door-open dwell. It sits between the button/panel logic and the elevator controller, and is the only block that drives the controller's request floor.

## Interface
- NUM_FLOORS, 8, number of floors; floors are one-hot, bit 0 is the lowest floor.
- DOOR_DWELL, 4, clock cycles the door stays open after arrival; must be ≥1.
- CNT_W, $clog2(DOOR_DWELL+1), dwell counter width; derived, not overridden.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserted (0) forces the reset state immediately.
- call_req  in  NUM_FLOORS  call pulses; any set bit registers a call for that floor; multiple bits allowed.
- cur_floor  in  NUM_FLOORS  one-hot current floor, from the controller.
- complete  in  1  controller arrival flag.
- hold  in  1  door-obstruction / overload hold; freezes the dwell count.
- target_floor  out  NUM_FLOORS  one-hot floor requested of the controller.
- target_valid  out  1  target_floor is meaningful and the car should move.
- pending  out  NUM_FLOORS  registered outstanding calls.
- door_open  out  1  door-open command.
- sched_dir  out  1  scan direction: 1 = up, 0 = down.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SELECT, MOVE, DOOR.
- Reset values: state IDLE, pending 0, target_floor 0, target_valid 0, door_open 0, sched_dir 1, busy 0, dwell counter 0.
- Call latching:
  - Every cycle, pending |= call_req.
  - Exception: a call for cur_floor is not latched while in DOOR. It restarts the dwell counter instead (door re-open).
  - Clearing a served floor's bit and setting a new bit in the same cycle: the set wins for other bits; the served bit is cleared.
- SCAN pick (combinational, from pending and cur_floor):
  - "above" = pending bits strictly higher than cur_floor; "below" = pending bits strictly lower.
  - If sched_dir=1: with above non-empty, pick the lowest bit of above. Otherwise, with below non-empty, pick the highest bit of below and flip the direction to 0.
  - Symmetric for sched_dir=0.
  - Pending bit equal to cur_floor: pick it with no direction change. This has the highest priority.
- IDLE: pending ≠ 0 → SELECT.
- SELECT:
  - If cur_floor is not exactly one-hot: stay in SELECT, target_valid=0.
  - If the pick equals cur_floor: go straight to DOOR.
  - Otherwise: register target_floor, update sched_dir, assert target_valid, → MOVE.
- MOVE:
  - target_valid stays 1.
  - If a new pending floor lies strictly between cur_floor and target_floor in the direction of travel, target_floor is replaced by it (pick-up on the way). The nearer floor to cur_floor wins.
  - complete=1 and cur_floor==target_floor → DOOR. target_valid is cleared and the target's pending bit is cleared.
  - complete with cur_floor≠target_floor is ignored.
- DOOR:
  - door_open=1. The dwell counter loads DOOR_DWELL on entry and decrements each cycle hold=0; hold=1 freezes it.
  - Count reaches 0 → door_open deasserts. Then pending≠0 → SELECT, else → IDLE.
- sched_dir changes only in SELECT. It retains its value through IDLE.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- A call_req pulse in cycle N appears in pending at N+1.
- From IDLE:
  - Call at N → SELECT at N+1 → target_valid=1 at N+2.
- Arrival:
  - complete sampled at cycle M → door_open=1 at M+1.
  - door_open stays high for DOOR_DWELL cycles when hold stays low; each hold cycle extends it by one.
- Door re-open: a cur_floor call during DOOR reloads the counter on the next edge.
- Reset:
  - reset low mid-MOVE or mid-DOOR drops target_valid and door_open asynchronously.
  - All pending calls are lost.
  - The first state update after release happens on the first posedge clk with reset high.

## Structure
- Package elevator_pkg holds:
  - the state enum for sched_state_t (IDLE, SELECT, MOVE, DOOR);
  - NUM_FLOORS and DOOR_DWELL defaults;
  - the DIR_UP/DIR_DOWN constants.
- Sub-module elevator_floor_picker: purely combinational SCAN pick.
  - Inputs: pending, cur_floor, dir.
  - Outputs: pick (one-hot), pick_valid, new_dir, at_cur.
  - Reused by SELECT and by the MOVE pick-up check.

## Test plan
- Single call up: cur_floor=8'h01, call_req=8'h10 pulse → target_floor=8'h10, target_valid two cycles later, sched_dir=1. After complete, door_open for exactly 4 cycles, then IDLE with pending=0.
- SCAN order: cur=8'h08, dir up, calls 8'h41 together → target 8'h40 first. After service, target 8'h01 with sched_dir=0.
- Pick-up on the way: MOVE toward 8'h80 from 8'h02, call 8'h10 arrives → target_floor becomes 8'h10 while MOVE continues; 8'h80 is served after.
- Hold and re-open: in DOOR, hold=1 for 3 cycles → door_open lasts 7 cycles. A call for cur_floor during DOOR restarts the dwell; pending is unchanged.
- Call at current floor from IDLE: cur=8'h04, call 8'h04 → DOOR with no target_valid pulse.
- Async reset mid-MOVE: reset low between edges → target_valid, door_open and pending are 0 immediately; sched_dir=1 after release.
